// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
//   Receive side of a multiplexed seven-segment bus. Samples the active-low segment lines and the
//   active-high per-digit anode enables, waits for each strobed digit to settle, decodes it back
//   to BCD and assembles a frame of DIGITS digits, presented with a valid/ack handshake.
//
//   Ports:
//     clk          rising-edge clock
//     n_reset      asynchronous active-low reset
//     seg_n        segments a..g on seg_n[6..0], active-low
//     an           anode enables, active-high, an[i] selects digit i
//     frame_bcd    digit i on frame_bcd[4i+3:4i] (4'hF for an undecodable pattern)
//     frame_blank  bit i set when digit i was dark
//     frame_valid  frame_bcd/frame_blank hold a complete, unacknowledged frame
//     frame_ack    consumer accepts the frame; only looked at while frame_valid is high
//     seg_err      1-cycle pulse: undecodable segment pattern captured, or multi-hot anode seen
//     overrun      1-cycle pulse: a new frame replaced one that was never acknowledged
//
//   Build option: define SEVEN_SEG_INPUT_SYNC_EN to pass seg_n/an through a 2-flop synchronizer
//   (adds 2 cycles to every latency) when the bus is asynchronous to clk.
module seven_seg_scan_decoder #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   frame_bcd,
    output logic [DIGITS-1:0]     frame_blank,
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic                  seg_err,
    output logic                  overrun
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StSettle, StCaptured} state_t;

    logic [6:0]        seg_s;
    logic [DIGITS-1:0] an_s;

`ifdef SEVEN_SEG_INPUT_SYNC_EN
    logic [6:0]        seg_m1, seg_m2;
    logic [DIGITS-1:0] an_m1, an_m2;

    // Reset to the "bus idle" value so nothing looks like a strobe after reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            seg_m1 <= 7'h7F;
            seg_m2 <= 7'h7F;
            an_m1  <= '0;
            an_m2  <= '0;
        end else begin
            seg_m1 <= seg_n;
            seg_m2 <= seg_m1;
            an_m1  <= an;
            an_m2  <= an_m1;
        end
    end

    assign seg_s = seg_m2;
    assign an_s  = an_m2;
`else
    assign seg_s = seg_n;
    assign an_s  = an;
`endif

    state_t                   state_q;
    logic [DIGITS+6:0]        prev_q;
    logic [CW-1:0]            cnt_q;
    logic [DIGITS-1:0]        seen_q;
    logic [4*DIGITS-1:0]      slot_bcd_q;
    logic [DIGITS-1:0]        slot_blank_q;

    logic [3:0]               dec_bcd;
    logic                     dec_blank;
    logic                     dec_illegal;

    always_comb begin
        dec_bcd     = 4'h0;
        dec_blank   = 1'b0;
        dec_illegal = 1'b0;
        case (seg_s)
            7'b0000001: dec_bcd = 4'd0;
            7'b1001111: dec_bcd = 4'd1;
            7'b0010010: dec_bcd = 4'd2;
            7'b0000110: dec_bcd = 4'd3;
            7'b1001100: dec_bcd = 4'd4;
            7'b0100100: dec_bcd = 4'd5;
            7'b0100000: dec_bcd = 4'd6;
            7'b0001111: dec_bcd = 4'd7;
            7'b0000000: dec_bcd = 4'd8;
            7'b0000100: dec_bcd = 4'd9;
            7'b1111111: dec_blank = 1'b1;
            default: begin
                dec_bcd     = 4'hF;
                dec_illegal = 1'b1;
            end
        endcase
    end

    logic [DIGITS+6:0] s_now;
    logic              same;
    logic              an_zero;
    logic              an_onehot;
    logic              an_multi;
    logic              fresh;
    logic [CW-1:0]     cnt_inc;
    logic              capture;
    logic              frame_done;

    assign s_now     = {an_s, seg_s};
    assign same      = (s_now == prev_q);
    assign an_zero   = (an_s == '0);
    assign an_onehot = $onehot(an_s);
    assign an_multi  = !an_zero && !an_onehot;
    // A sample gets the IDLE treatment in IDLE, or whenever it differs from the previous one.
    assign fresh     = (state_q == StIdle) || !same;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign capture   = fresh ? (an_onehot && (STABLE_CYCLES == 1))
                             : ((state_q == StSettle) && (cnt_inc == CNT_MAX));
    assign frame_done = &seen_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= StIdle;
            prev_q  <= {{DIGITS{1'b0}}, 7'h7F};
            cnt_q   <= '0;
            seg_err <= 1'b0;
        end else begin
            prev_q  <= s_now;
            // Multi-hot flagged once per distinct offending sample, so the pulse cannot stick.
            seg_err <= (!same && an_multi) || (capture && dec_illegal);
            if (fresh) begin
                if (an_onehot) begin
                    cnt_q   <= CW'(1);
                    state_q <= capture ? StCaptured : StSettle;
                end else begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            end else if (state_q == StSettle) begin
                cnt_q <= cnt_inc;
                if (capture) begin
                    state_q <= StCaptured;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            seen_q       <= '0;
            slot_bcd_q   <= '0;
            slot_blank_q <= '0;
            frame_bcd    <= '0;
            frame_blank  <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // capture implies an_s is one-hot, so it doubles as the slot select.
            seen_q <= (frame_done ? '0 : seen_q) | (capture ? an_s : '0);
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (capture && an_s[i]) begin
                    slot_bcd_q[4*i +: 4] <= dec_bcd;
                    slot_blank_q[i]      <= dec_blank;
                end
            end
            if (frame_done) begin
                frame_bcd   <= slot_bcd_q;
                frame_blank <= slot_blank_q;
                frame_valid <= 1'b1;
                overrun     <= frame_valid && !frame_ack;
            end else begin
                overrun <= 1'b0;
                if (frame_valid && frame_ack) begin
                    frame_valid <= 1'b0;
                end
            end
        end
    end

endmodule
